// File: rtl/encode8to3_seq_if.sv
// Handshake bundle for encode8to3_seq: request-vector input channel,
// index output channel and the status outputs (popcount, zero-vector flag).
// The slave modport is the encoder side; the master modport is the
// producer/consumer side that drives requests and accepts indices.
interface encode8to3_seq_if #(
    parameter int N_IN  = 8,
    parameter int IDX_W = 3,
    parameter int CNT_W = 4
);
    logic [N_IN-1:0]  In;
    logic             in_valid;
    logic             in_ready;
    logic [IDX_W-1:0] Out;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic [CNT_W-1:0] bit_cnt;
    logic             zero_err;

    modport slave (
        input  In,
        input  in_valid,
        output in_ready,
        output Out,
        output out_valid,
        input  out_ready,
        output out_last,
        output bit_cnt,
        output zero_err
    );

    modport master (
        output In,
        output in_valid,
        input  in_ready,
        input  Out,
        input  out_valid,
        output out_ready,
        input  out_last,
        input  bit_cnt,
        input  zero_err
    );
endinterface

// File: rtl/encode8to3_seq.sv
// Sequential 8-to-3 encoder: captures a request vector over a valid/ready
// handshake, then emits the binary index of every set bit, one per output
// transfer. Scan order is lowest bit first; defining ENC_MSB_FIRST_EN
// reverses it to highest bit first. All outputs come straight from flops.
module encode8to3_seq #(
    parameter int N_IN  = 8,
    parameter int IDX_W = 3,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    encode8to3_seq_if.slave  bus
);

    if (IDX_W != $clog2(N_IN)) begin : g_bad_idx_w
        $error("encode8to3_seq: IDX_W must equal clog2(N_IN)");
    end
    if ((64'd1 << CNT_W) <= 64'(N_IN)) begin : g_bad_cnt_w
        $error("encode8to3_seq: CNT_W too narrow to hold N_IN");
    end

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Number of set bits in a vector.
    function automatic logic [CNT_W-1:0] popcount(input logic [N_IN-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < N_IN; i++) begin
            c = c + {{(CNT_W-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

    // Index of the next bit to emit (lowest or highest set bit).
    function automatic logic [IDX_W-1:0] scan_idx(input logic [N_IN-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
`ifdef ENC_MSB_FIRST_EN
        for (int i = 0; i < N_IN; i++) begin
            if (v[i]) begin
                idx = IDX_W'(i);
            end else begin
                idx = idx;
            end
        end
`else
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = IDX_W'(i);
            end else begin
                idx = idx;
            end
        end
`endif
        return idx;
    endfunction

    // True when exactly one bit of the vector is set.
    function automatic logic is_single(input logic [N_IN-1:0] v);
        return (v != '0) && ((v & (v - {{(N_IN-1){1'b0}}, 1'b1})) == '0);
    endfunction

    // One-hot mask selecting bit idx.
    function automatic logic [N_IN-1:0] bit_mask(input logic [IDX_W-1:0] idx);
        logic [N_IN-1:0] one;
        one = {{(N_IN-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

    state_t           state_q,     state_d;
    logic [N_IN-1:0]  pending_q,   pending_d;
    logic [IDX_W-1:0] out_q,       out_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q,  out_last_d;
    logic [CNT_W-1:0] bit_cnt_q,   bit_cnt_d;
    logic             zero_err_q,  zero_err_d;
    logic             in_ready_q,  in_ready_d;
    logic             capture_s;
    logic             xfer_s;
    logic [N_IN-1:0]  remain_s;

    // Next-state and next-output logic for the IDLE/EMIT controller.
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        bit_cnt_d   = bit_cnt_q;
        zero_err_d  = 1'b0;
        in_ready_d  = in_ready_q;
        capture_s   = 1'b0;
        xfer_s      = 1'b0;
        remain_s    = pending_q & ~bit_mask(out_q);

        case (state_q)
            IDLE: begin
                capture_s = bus.in_valid && in_ready_q;
                if (capture_s) begin
                    pending_d = bus.In;
                    bit_cnt_d = popcount(bus.In);
                    if (bus.In != '0) begin
                        // Non-zero vector: first index visible next cycle.
                        state_d     = EMIT;
                        out_d       = scan_idx(bus.In);
                        out_valid_d = 1'b1;
                        out_last_d  = is_single(bus.In);
                        in_ready_d  = 1'b0;
                    end else begin
                        // Zero vector: flag it, stay ready, emit nothing.
                        zero_err_d  = 1'b1;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        in_ready_d  = 1'b1;
                    end
                end else begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            EMIT: begin
                xfer_s = out_valid_q && bus.out_ready;
                if (xfer_s) begin
                    pending_d = remain_s;
                    if (out_last_q) begin
                        // Final index taken: ready again next cycle, no overlap.
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        in_ready_d  = 1'b1;
                    end else begin
                        out_d      = scan_idx(remain_s);
                        out_last_d = is_single(remain_s);
                        in_ready_d = 1'b0;
                    end
                end else begin
                    // Backpressure: hold everything stable.
                    in_ready_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                pending_d   = '0;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            bit_cnt_q   <= '0;
            zero_err_q  <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            bit_cnt_q   <= bit_cnt_d;
            zero_err_q  <= zero_err_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.Out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.bit_cnt   = bit_cnt_q;
    assign bus.zero_err  = zero_err_q;

endmodule

// File: tb/tb_encode8to3_seq.sv
// Directed testbench for encode8to3_seq. Inputs change 1 time unit after
// the rising edge; outputs are checked at the same point.
module tb_encode8to3_seq;

`ifdef ENC_MSB_FIRST_EN
    localparam bit MSB = 1'b1;
`else
    localparam bit MSB = 1'b0;
`endif

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    encode8to3_seq_if #(.N_IN(8), .IDX_W(3), .CNT_W(4)) bus ();

    encode8to3_seq #(.N_IN(8), .IDX_W(3), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_reset(input string tag);
        chk({tag, "_out"},      32'(bus.Out),       32'd0);
        chk({tag, "_valid"},    32'(bus.out_valid), 32'd0);
        chk({tag, "_last"},     32'(bus.out_last),  32'd0);
        chk({tag, "_cnt"},      32'(bus.bit_cnt),   32'd0);
        chk({tag, "_zerr"},     32'(bus.zero_err),  32'd0);
        chk({tag, "_in_ready"}, 32'(bus.in_ready),  32'd0);
    endtask

    task automatic chk_emit(input string tag, input logic [2:0] idx, input logic last);
        chk({tag, "_out"},      32'(bus.Out),       32'(idx));
        chk({tag, "_valid"},    32'(bus.out_valid), 32'd1);
        chk({tag, "_last"},     32'(bus.out_last),  32'(last));
        chk({tag, "_in_ready"}, 32'(bus.in_ready),  32'd0);
    endtask

    initial begin
        logic [2:0] seq3 [3];
        logic [2:0] idx;
        checks       = 0;
        failures     = 0;
        reset        = 1'b1;
        bus.In       = 8'h00;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;

        // 1. reset held two cycles, then idle
        tick();
        chk_idle_reset("rst1");
        tick();
        chk_idle_reset("rst2");
        reset = 1'b0;
        tick();
        chk("idle_in_ready", 32'(bus.in_ready),  32'd1);
        chk("idle_valid",    32'(bus.out_valid), 32'd0);
        tick();
        chk("idle_valid2",   32'(bus.out_valid), 32'd0);

        // 2. single bit
        bus.In = 8'b0010_0000; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk_emit("single", 3'd5, 1'b1);
        chk("single_cnt", 32'(bus.bit_cnt), 32'd1);
        tick();
        chk("single_done_valid", 32'(bus.out_valid), 32'd0);
        chk("single_done_ready", 32'(bus.in_ready),  32'd1);

        // 3. multi-bit with backpressure
        seq3[0] = MSB ? 3'd7 : 3'd0;
        seq3[1] = 3'd2;
        seq3[2] = MSB ? 3'd0 : 3'd7;
        bus.In = 8'b1000_0101; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        chk("multi_cnt", 32'(bus.bit_cnt), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk_emit("multi_hold", seq3[0], 1'b0);
            tick();
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk_emit("multi_seq", seq3[i], (i == 2));
            tick();
        end
        chk("multi_done_valid", 32'(bus.out_valid), 32'd0);
        chk("multi_done_ready", 32'(bus.in_ready),  32'd1);

        // 4. zero vector
        bus.In = 8'h00; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("zero_err",   32'(bus.zero_err),  32'd1);
        chk("zero_valid", 32'(bus.out_valid), 32'd0);
        chk("zero_ready", 32'(bus.in_ready),  32'd1);
        chk("zero_cnt",   32'(bus.bit_cnt),   32'd0);
        tick();
        chk("zero_err_pulse", 32'(bus.zero_err),  32'd0);
        chk("zero_valid2",    32'(bus.out_valid), 32'd0);

        // 5. full vector, in_valid held while busy
        bus.In = 8'hFF; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        tick();
        bus.In = 8'h03;
        chk("full_cnt", 32'(bus.bit_cnt), 32'd8);
        for (int i = 0; i < 8; i++) begin
            idx = MSB ? 3'(7 - i) : 3'(i);
            chk_emit("full_seq", idx, (i == 7));
            chk("full_cnt_hold", 32'(bus.bit_cnt), 32'd8);
            tick();
        end
        chk("full_no_overlap_valid", 32'(bus.out_valid), 32'd0);
        chk("full_no_overlap_ready", 32'(bus.in_ready),  32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk_emit("second_a", MSB ? 3'd1 : 3'd0, 1'b0);
        chk("second_cnt", 32'(bus.bit_cnt), 32'd2);
        tick();
        chk_emit("second_b", MSB ? 3'd0 : 3'd1, 1'b1);
        tick();
        chk("second_done_valid", 32'(bus.out_valid), 32'd0);

        // 6. reset mid-stream
        bus.In = 8'b0101_0101; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk_emit("mid_a", MSB ? 3'd6 : 3'd0, 1'b0);
        tick();
        chk_emit("mid_b", MSB ? 3'd4 : 3'd2, 1'b0);
        tick();
        chk_emit("mid_c", MSB ? 3'd2 : 3'd4, 1'b0);
        reset = 1'b1;
        tick();
        chk_idle_reset("mid_rst");
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_valid", 32'(bus.out_valid), 32'd0);
            chk("post_rst_ready", 32'(bus.in_ready),  32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
